// File: rtl/decode_pipe_stage.sv
// Instruction-decode stage: register file, hazard detection, in-decode
// branch/jump resolution, sticky halt and the ID/EX pipeline register.
module decode_pipe_stage #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned NB_PC   = 7
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               if_valid_i,
    input  logic [31:0]        instr_i,
    input  logic [NB_PC-1:0]   pc_i,
    input  logic               wb_we_i,
    input  logic [NB_REG-1:0]  wb_addr_i,
    input  logic [NB_DATA-1:0] wb_data_i,
    input  logic               ex_mem_read_i,
    input  logic               ex_reg_write_i,
    input  logic [NB_REG-1:0]  ex_rd_i,
    input  logic               mem_mem_read_i,
    input  logic               mem_reg_write_i,
    input  logic [NB_REG-1:0]  mem_rd_i,
    input  logic [NB_DATA-1:0] mem_alu_result_i,
    input  logic [NB_REG-1:0]  dbg_addr_i,
    output logic [NB_DATA-1:0] dbg_data_o,
    output logic               stall_o,
    output logic               branch_taken_o,
    output logic [NB_PC-1:0]   pc_target_o,
    output logic               halted_o,
    output logic               ex_valid_o,
    output logic               ex_reg_write_o,
    output logic               ex_mem_read_o,
    output logic               ex_mem_write_o,
    output logic [5:0]         ex_opcode_o,
    output logic [5:0]         ex_funct_o,
    output logic [NB_REG-1:0]  ex_rs_o,
    output logic [NB_REG-1:0]  ex_rt_o,
    output logic [NB_REG-1:0]  ex_rd_o,
    output logic [NB_DATA-1:0] ex_data_a_o,
    output logic [NB_DATA-1:0] ex_data_b_o,
    output logic [NB_DATA-1:0] ex_imm_o
);

    localparam int unsigned DEPTH = 2 ** NB_REG;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_HALT  = 6'h3F;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic [5:0]         opcode;
        logic [5:0]         funct;
        logic [NB_REG-1:0]  rs;
        logic [NB_REG-1:0]  rt;
        logic [NB_REG-1:0]  rd;
        logic [NB_DATA-1:0] data_a;
        logic [NB_DATA-1:0] data_b;
        logic [NB_DATA-1:0] imm;
    } id_ex_t;

    logic [NB_DATA-1:0] rf_q [DEPTH];
    id_ex_t             idex_q, idex_d;
    logic               halted_q, halted_d;

    // Instruction fields
    logic [5:0]         op, funct;
    logic [NB_REG-1:0]  rs, rt, rd, dest;
    logic [15:0]        imm16;
    logic [NB_DATA-1:0] imm_sext;

    assign op       = instr_i[31:26];
    assign funct    = instr_i[5:0];
    assign rs       = NB_REG'(instr_i[25:21]);
    assign rt       = NB_REG'(instr_i[20:16]);
    assign rd       = NB_REG'(instr_i[15:11]);
    assign imm16    = instr_i[15:0];
    assign imm_sext = {{(NB_DATA-16){imm16[15]}}, imm16};

    // Register-file reads with same-cycle write-through
    logic [NB_DATA-1:0] rs_val, rt_val;

    assign rs_val = (rs == '0) ? '0 :
                    (wb_we_i && wb_addr_i == rs) ? wb_data_i : rf_q[rs];
    assign rt_val = (rt == '0) ? '0 :
                    (wb_we_i && wb_addr_i == rt) ? wb_data_i : rf_q[rt];
    assign dbg_data_o = (dbg_addr_i == '0) ? '0 :
                        (wb_we_i && wb_addr_i == dbg_addr_i) ? wb_data_i : rf_q[dbg_addr_i];

    // Opcode classification and control decode
    logic is_rtype, is_jr, is_j, is_jal, is_beq, is_bne, is_halt;
    logic is_alui, is_load, is_store, is_br_op;
    logic reg_write, reads_rs, reads_rt, use_rs, use_rt;

    always_comb begin
        is_rtype  = (op == OP_RTYPE);
        is_jr     = is_rtype && (funct == FN_JR);
        is_j      = (op == OP_J);
        is_jal    = (op == OP_JAL);
        is_beq    = (op == OP_BEQ);
        is_bne    = (op == OP_BNE);
        is_halt   = (op == OP_HALT);
        is_alui   = (op >= 6'h08) && (op <= 6'h0F);
        is_load   = (op >= 6'h20) && (op <= 6'h25);
        is_store  = (op >= 6'h28) && (op <= 6'h2B);
        is_br_op  = is_beq || is_bne || is_jr;
        reg_write = (is_rtype && !is_jr) || is_alui || is_load || is_jal;
        // lui has no source register; jumps and halt read nothing
        reads_rs  = is_rtype || is_beq || is_bne || is_load || is_store
                    || (is_alui && op != OP_LUI);
        reads_rt  = (is_rtype && !is_jr) || is_beq || is_bne || is_store;
        use_rs    = reads_rs && (rs != '0);
        use_rt    = reads_rt && (rt != '0);
        if (is_rtype) begin
            dest = rd;
        end else if (is_jal) begin
            dest = NB_REG'(5'd31);
        end else begin
            dest = rt;
        end
    end

    // Hazard detection
    logic active, load_use, br_ex, br_mem, stall, resolve;

    always_comb begin
        active   = if_valid_i && enable_i && !halted_q;
        load_use = ex_mem_read_i &&
                   ((use_rs && ex_rd_i == rs) || (use_rt && ex_rd_i == rt));
        br_ex    = is_br_op && ex_reg_write_i &&
                   ((use_rs && ex_rd_i == rs) || (use_rt && ex_rd_i == rt));
        br_mem   = is_br_op && mem_mem_read_i &&
                   ((use_rs && mem_rd_i == rs) || (use_rt && mem_rd_i == rt));
        stall    = active && (load_use || br_ex || br_mem);
        resolve  = active && !stall;
    end

    // Comparator operands, forwarded from a non-load ALU result in MEM
    logic [NB_DATA-1:0] cmp_a, cmp_b;

    always_comb begin
        cmp_a = rs_val;
        cmp_b = rt_val;
        if (mem_reg_write_i && !mem_mem_read_i && rs != '0 && mem_rd_i == rs) begin
            cmp_a = mem_alu_result_i;
        end
        if (mem_reg_write_i && !mem_mem_read_i && rt != '0 && mem_rd_i == rt) begin
            cmp_b = mem_alu_result_i;
        end
    end

    // Branch/jump resolution and redirect target
    logic [NB_PC-1:0] pc_plus1, target;
    logic             taken;

    always_comb begin
        pc_plus1 = pc_i + NB_PC'(1);
        target   = pc_plus1 + NB_PC'(imm_sext);
        if (is_j || is_jal) begin
            target = NB_PC'(instr_i);
        end else if (is_jr) begin
            target = NB_PC'(cmp_a);
        end
        taken = resolve && ((is_beq && cmp_a == cmp_b) || (is_bne && cmp_a != cmp_b)
                            || is_j || is_jal || is_jr);
    end

    assign stall_o        = stall;
    assign branch_taken_o = taken;
    assign pc_target_o    = target;

    // ID/EX next value: hold, bubble or issue
    always_comb begin
        idex_d   = idex_q;
        halted_d = halted_q;
        if (enable_i) begin
            halted_d = halted_q || (resolve && is_halt);
            if (!if_valid_i || stall || halted_q || is_halt) begin
                idex_d = '0;
            end else begin
                idex_d.valid     = 1'b1;
                idex_d.reg_write = reg_write;
                idex_d.mem_read  = is_load;
                idex_d.mem_write = is_store;
                idex_d.opcode    = op;
                idex_d.funct     = funct;
                idex_d.rs        = rs;
                idex_d.rt        = rt;
                idex_d.rd        = dest;
                idex_d.data_a    = is_jal ? NB_DATA'(pc_plus1) : rs_val;
                idex_d.data_b    = rt_val;
                idex_d.imm       = imm_sext;
            end
        end
    end

    // ID/EX register and halt latch
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            idex_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            idex_q   <= idex_d;
            halted_q <= halted_d;
        end
    end

    // Register-file write port, independent of enable_i; r0 is never written
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rf_q <= '{default: '0};
        end else if (wb_we_i && wb_addr_i != '0) begin
            rf_q[wb_addr_i] <= wb_data_i;
        end
    end

    assign halted_o       = halted_q;
    assign ex_valid_o     = idex_q.valid;
    assign ex_reg_write_o = idex_q.reg_write;
    assign ex_mem_read_o  = idex_q.mem_read;
    assign ex_mem_write_o = idex_q.mem_write;
    assign ex_opcode_o    = idex_q.opcode;
    assign ex_funct_o     = idex_q.funct;
    assign ex_rs_o        = idex_q.rs;
    assign ex_rt_o        = idex_q.rt;
    assign ex_rd_o        = idex_q.rd;
    assign ex_data_a_o    = idex_q.data_a;
    assign ex_data_b_o    = idex_q.data_b;
    assign ex_imm_o       = idex_q.imm;

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Parametrised instruction-decode stage with an integrated register file, hazard detection, in-decode branch/jump resolution and the ID/EX pipeline register. It sits between the IF/ID register and the execute stage. It generalises the previous decode stage in data width, register count and PC width. It adds these behaviours:
- load-use and branch-operand stall detection;
- write-through register bypass;
- a sticky halt latch;
- a registered ID/EX output with bubble insertion.

## Interface
Parameters:
- NB_DATA, 32, datapath and register width
- NB_REG, 5, register index width; register file depth is 2**NB_REG
- NB_PC, 7, instruction-address width (word addressed)

Ports (clock and reset first):
- clock_i  in  1  rising-edge clock, single clock domain
- reset_i  in  1  asynchronous, active-low reset
- enable_i  in  1  stage advance enable (debug step); 0 freezes all stage state
- if_valid_i  in  1  instr_i/pc_i hold a real instruction
- instr_i  in  32  instruction from IF/ID
- pc_i  in  NB_PC  address of instr_i
- wb_we_i, wb_addr_i, wb_data_i  in  1/NB_REG/NB_DATA  register-file write port
- ex_mem_read_i, ex_reg_write_i, ex_rd_i  in  1/1/NB_REG  instruction currently in EX (fed back from ex_* outputs)
- mem_mem_read_i, mem_reg_write_i, mem_rd_i, mem_alu_result_i  in  1/1/NB_REG/NB_DATA  instruction in MEM
- dbg_addr_i  in  NB_REG  debug read address
- dbg_data_o  out  NB_DATA  combinational read of register dbg_addr_i
- stall_o  out  1  hold PC and IF/ID this cycle
- branch_taken_o  out  1  redirect PC and flush IF/ID
- pc_target_o  out  NB_PC  redirect address
- halted_o  out  1  sticky halt flag
- ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o  out  1 each  ID/EX control
- ex_opcode_o, ex_funct_o  out  6 each
- ex_rs_o, ex_rt_o, ex_rd_o  out  NB_REG each  (ex_rd_o is the resolved destination)
- ex_data_a_o, ex_data_b_o, ex_imm_o  out  NB_DATA each  (ex_imm_o is sign-extended)

## Operation
Field decode:
- op = instr[31:26], rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], funct = instr[5:0], imm = instr[15:0].
- Register indices are the low NB_REG bits of each field.

Register file:
- Register 0 reads 0; writes to it are ignored.
- Writes occur on the clock edge when wb_we_i=1, independent of enable_i.
- Same-cycle write-through: a read of wb_addr_i (non-zero) while wb_we_i=1 returns wb_data_i. This also applies to dbg_data_o.

Control decode:
- reg_write is set for: op=0x00 except funct 0x08 (jr); op 0x08–0x0F; op 0x20–0x25; op 0x03 (jal).
- mem_read is set for op 0x20–0x25. mem_write is set for op 0x28–0x2B.
- Destination: rd for op=0x00; 31 for jal; rt otherwise.

Hazard and stall (use = source index non-zero and the instruction reads it):
- Load-use: ex_mem_read_i=1 and ex_rd_i equals a used rs/rt.
- Branch/jr operand in EX: decode holds beq/bne/jr and ex_reg_write_i=1 with ex_rd_i equal to a used source.
- Branch/jr operand loading in MEM: mem_mem_read_i=1 with mem_rd_i equal to a used source.
- stall_o = if_valid_i & enable_i & !halted_o & (any hazard above).

Branch operand forwarding:
- If mem_reg_write_i=1, !mem_mem_read_i, and mem_rd_i equals a non-zero source, the comparator uses mem_alu_result_i for that source. Otherwise it uses the register-file value.

Branch resolution (only when if_valid_i & enable_i & !stall_o & !halted_o):
- beq (0x04) is taken if the operands are equal; bne (0x05) is taken if they differ.
- Branch target = pc_i + 1 + sext(imm), truncated to NB_PC.
- j (0x02) and jal (0x03) target instr[NB_PC-1:0].
- jr targets the forwarded rs value [NB_PC-1:0].
- jal writes pc_i + 1, zero-extended, through ex_data_a_o.

Halt:
- op=0x3F with valid, enabled and not stalled sets halted_o.
- halted_o clears only on reset.
- While halted_o=1, only bubbles are issued and branch_taken_o=0.

## Timing
- Reset (reset_i=0, asynchronous): all ex_* outputs, halted_o and every register go to 0.
- stall_o, branch_taken_o and pc_target_o are combinational, valid in the same cycle as instr_i.
- ID/EX updates on the rising edge when enable_i=1, giving one cycle of latency.
- A bubble is loaded (ex_valid_o and all control bits 0, data fields don't-care but 0) when any of these hold: !if_valid_i, stall_o, halted_o, or the instruction is halt.
- enable_i=0: ID/EX and halted_o hold their values; stall_o=0; branch_taken_o=0.
- The branch instruction itself is passed into EX with reg_write=0, except jal. The upstream flush of IF/ID uses branch_taken_o.
- When stall and branch conditions coincide, the stall wins: branch_taken_o=0 and resolution is retried the next cycle.

## Test plan
- Reset mid-run: with ex_valid_o=1, pulse reset_i low asynchronously (not aligned to a clock edge) -> all outputs are 0 immediately, and register 5 reads 0.
- Write-through: wb_we_i=1, wb_addr_i=3, wb_data_i=0xDEAD while decoding add r1,r3,r0 -> ex_data_a_o=0xDEAD the next cycle.
- Load-use: EX holds lw r2 and decode holds add r4,r2,r2 -> stall_o=1 and a bubble is issued; the following cycle the add is issued with stall_o=0.
- Branch forwarding: MEM has reg_write to r6 with mem_alu_result_i=7, r7=7, decode holds beq r6,r7,-2 at pc=10 -> branch_taken_o=1 and pc_target_o=9.
- Jump and jr: j 0x15 -> pc_target_o=0x15. jr r8 with r8=0x1FF and NB_PC=7 -> pc_target_o=0x7F.
- Halt: decode 0xFC000000 -> halted_o=1 from the next edge; later valid instructions produce only bubbles until reset.
